core_mc: RTL and testbench
==========================

Name: core_mc

Overview:
- Multi-cycle RV32I core top, successor of the single-cycle core.
- Fetch, execute and memory phases are sequenced by an FSM. Instruction and data memories use a req/ack handshake with arbitrary wait states.
- Existing core_regfile, core_alu and core_ctrl are reused unchanged; this block adds the sequencing, commit gating, halt/error handling and counters.
- Sits between the SoC memory fabric and the datapath.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- HALT_ON_EBREAK, 1: 1 = EBREAK (32'h0010_0073) halts the core; 0 = EBREAK treated as NOP.
- CNT_W, 32: width of the cycle and instret counters (1..64).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  leave IDLE; sampled only in IDLE
- i_req  out  1  instruction fetch request
- i_addr  out  32  fetch address (= pc)
- i_ack  in  1  fetch complete; i_rdata valid this cycle
- i_rdata  in  32  instruction word
- d_req  out  1  data access request
- d_addr  out  32  data address
- d_wen  out  4  byte write enables; 0 = load
- d_wdata  out  32  store data
- d_ack  in  1  access complete; d_rdata valid this cycle for loads
- d_rdata  in  32  load data
- halted  out  1  core stopped (EBREAK or error)
- err  out  1  misaligned-fetch error sticky flag
- retire  out  1  one-cycle pulse per committed instruction
- pc_o  out  32  architectural pc
- cycle_cnt  out  CNT_W  cycles spent in FETCH/EXEC/MEM
- instret_cnt  out  CNT_W  committed instructions

Behaviour:
- Reset values (async, immediate on rstn low): state=IDLE, pc=RESET_PC, ir=0, all req/wen=0, halted=0, err=0, retire=0, counters=0. Reset mid-handshake drops i_req/d_req in the same instant; any late ack after reset is ignored.
- States and transitions:
  - IDLE: start=1 -> FETCH.
  - FETCH: i_req=1, i_addr=pc held stable until i_ack. On i_ack: ir<=i_rdata -> EXEC.
  - EXEC: core_ctrl evaluates ir/pc.
    - EBREAK with HALT_ON_EBREAK=1 -> HALT (retire counts it).
    - opcode 0000011 (load) or 0100011 (store) -> MEM, no commit yet.
    - Otherwise commit this cycle -> FETCH.
  - MEM: d_req=1, with d_addr/d_wen/d_wdata from core_ctrl held stable until d_ack. The d_mem_data input of core_ctrl is driven from d_rdata. On d_ack: commit -> FETCH.
  - HALT: absorbing until reset. All req=0; start ignored.
- Commit cycle actions:
  - Regfile write enable = core_ctrl wreg AND commit; never written outside commit.
  - pc <= nextpc; retire=1; instret_cnt += 1.
  - If nextpc[1:0] != 0: pc is not updated, err<=1 -> HALT (the faulting instruction still retires).
- d_wen is nonzero only in MEM; loads drive d_wen=0.
- i_ack outside FETCH and d_ack outside MEM are ignored.
- An ack may arrive in the first request cycle. Minimum latency: 2 cycles per ALU/branch instruction, 3 per load/store.
- cycle_cnt increments every cycle in FETCH/EXEC/MEM.
- Both counters wrap modulo 2^CNT_W silently.
- x0 writes are discarded by core_regfile.
- halted=1 whenever state is HALT.

Decomposition:
- Package core_mc_pkg:
  - state enum (IDLE, FETCH, EXEC, MEM, HALT)
  - OPC_LOAD=7'b0000011, OPC_STORE=7'b0100011, INSN_EBREAK=32'h0010_0073
- One new sub-module, core_mc_fsm: state register, next-state logic, commit/req generation, halt/err.
- Top core_mc instantiates core_mc_fsm, core_regfile, core_alu and core_ctrl, and holds pc, ir and the counters.

Test Plan:
- Reset with RESET_PC=32'h100, then start pulse. Expect i_req=1, i_addr=32'h100 next cycle. Supply ADDI x1,x0,5 with i_ack after 3 wait cycles. Expect x1=5, retire pulse once, pc_o=32'h104, cycle_cnt=5.
- SW x1,8(x0) after x1=5, with d_ack delayed 4 cycles. Expect d_addr=8 and d_wdata=5 stable throughout, d_wen=4'hF, and no retire until the d_ack cycle.
- LW x2,8(x0) with d_rdata=32'hDEAD_BEEF. Expect x2=32'hDEAD_BEEF and d_wen=0. Also issue a spurious d_ack during FETCH: expect no effect.
- JALR to an address with bit 1 set (e.g. 32'h102). Expect err=1, halted=1, pc_o unchanged, instret incremented, i_req stays 0.
- EBREAK with HALT_ON_EBREAK=1. Expect halted=1 and start ignored. With HALT_ON_EBREAK=0: expect pc advances by 4 and execution continues.
- Assert rstn low while d_req=1 mid-wait. Expect d_req=0 immediately, pc=RESET_PC, counters=0, state IDLE. An ack arriving after reset release causes no regfile write.

Source files
------------

// File: rtl/core_mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I core.
package core_mc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_HALT
  } state_t;

  localparam logic [6:0]  OPC_LOAD    = 7'b0000011;
  localparam logic [6:0]  OPC_STORE   = 7'b0100011;
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

  function automatic logic is_mem_op(input logic [31:0] insn);
    return (insn[6:0] == OPC_LOAD) || (insn[6:0] == OPC_STORE);
  endfunction

endpackage

// File: rtl/core_alu.sv
// RV32I integer ALU; op = {funct7[5], funct3}.
module core_alu (
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic signed [31:0] sa;
  logic signed [31:0] sb;

  assign sa = a;
  assign sb = b;

  always_comb begin
    y = '0;
    case (op[2:0])
      3'b000: y = op[3] ? (a - b) : (a + b);
      3'b001: y = a << b[4:0];
      3'b010: y = {31'b0, (sa < sb)};
      3'b011: y = {31'b0, (a < b)};
      3'b100: y = a ^ b;
      3'b101: y = op[3] ? 32'(sa >>> b[4:0]) : (a >> b[4:0]);
      3'b110: y = a | b;
      3'b111: y = a & b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/core_ctrl.sv
// RV32I decode: operand selection, writeback value, next pc and data-memory request fields.
module core_ctrl (
  input  logic [31:0] ir,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] alu_y,
  input  logic [31:0] d_mem_data,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic        wreg,
  output logic [31:0] wdata,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [31:0] nextpc,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_wdata
);

  logic [6:0]         opc;
  logic [2:0]         f3;
  logic signed [31:0] imm_i, imm_s, imm_b, imm_j;
  logic [31:0]        imm_u, pc4, ld_sh, ld_val;
  logic               taken;

  assign opc      = ir[6:0];
  assign f3       = ir[14:12];
  assign rd_addr  = ir[11:7];
  assign rs1_addr = ir[19:15];
  assign rs2_addr = ir[24:20];
  assign imm_i    = {{20{ir[31]}}, ir[31:20]};
  assign imm_s    = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b    = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j    = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign imm_u    = {ir[31:12], 12'b0};
  assign pc4      = pc + 32'd4;
  assign mem_addr = alu_y;
  assign ld_sh    = d_mem_data >> {mem_addr[1:0], 3'b000};

  always_comb begin
    case (f3)
      3'b000:  ld_val = {{24{ld_sh[7]}}, ld_sh[7:0]};
      3'b001:  ld_val = {{16{ld_sh[15]}}, ld_sh[15:0]};
      3'b100:  ld_val = {24'b0, ld_sh[7:0]};
      3'b101:  ld_val = {16'b0, ld_sh[15:0]};
      default: ld_val = d_mem_data;
    endcase
  end

  always_comb begin
    case (f3)
      3'b000:  taken = (rs1_data == rs2_data);
      3'b001:  taken = (rs1_data != rs2_data);
      3'b100:  taken = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  taken = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  taken = (rs1_data <  rs2_data);
      3'b111:  taken = (rs1_data >= rs2_data);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    alu_op    = 4'b0000;
    alu_a     = rs1_data;
    alu_b     = imm_i;
    wreg      = 1'b0;
    wdata     = alu_y;
    nextpc    = pc4;
    mem_wen   = 4'b0000;
    mem_wdata = rs2_data;
    case (opc)
      7'b0110111: begin wreg = 1'b1; wdata = imm_u; end
      7'b0010111: begin wreg = 1'b1; wdata = pc + imm_u; end
      7'b1101111: begin wreg = 1'b1; wdata = pc4; nextpc = pc + imm_j; end
      7'b1100111: begin wreg = 1'b1; wdata = pc4; nextpc = {alu_y[31:1], 1'b0}; end
      7'b1100011: if (taken) nextpc = pc + imm_b;
      7'b0000011: begin wreg = 1'b1; wdata = ld_val; end
      7'b0100011: begin
        alu_b = imm_s;
        case (f3)
          3'b000:  begin mem_wen = 4'b0001 << mem_addr[1:0];       mem_wdata = {4{rs2_data[7:0]}};  end
          3'b001:  begin mem_wen = 4'b0011 << {mem_addr[1], 1'b0}; mem_wdata = {2{rs2_data[15:0]}}; end
          default: mem_wen = 4'b1111;
        endcase
      end
      7'b0010011: begin wreg = 1'b1; alu_op = {(f3 == 3'b101) & ir[30], f3}; end
      7'b0110011: begin wreg = 1'b1; alu_b = rs2_data; alu_op = {ir[30], f3}; end
      default: ;
    endcase
  end

endmodule

// File: rtl/core_mc_fsm.sv
// Phase sequencer: fetch/exec/mem handshakes, commit strobe, halt and misaligned-fetch error.
module core_mc_fsm
  import core_mc_pkg::*;
#(
  parameter bit HALT_ON_EBREAK = 1'b1
) (
  input  logic   clk,
  input  logic   rstn,
  input  logic   start,
  input  logic   i_ack,
  input  logic   d_ack,
  input  logic   is_mem,
  input  logic   is_ebreak,
  input  logic   misaligned,
  output state_t state,
  output logic   i_req,
  output logic   d_req,
  output logic   halted,
  output logic   err,
  output logic   commit,
  output logic   ir_load
);

  // Loads/stores commit on d_ack; everything else, including a halting EBREAK, commits in EXEC.
  always_comb begin
    commit = 1'b0;
    case (state)
      ST_EXEC: commit = !is_mem;
      ST_MEM:  commit = d_ack;
      default: commit = 1'b0;
    endcase
  end

  assign ir_load = (state == ST_FETCH) && i_ack;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= ST_IDLE;
      i_req  <= 1'b0;
      d_req  <= 1'b0;
      halted <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state <= ST_FETCH;
          i_req <= 1'b1;
        end
        ST_FETCH: if (i_ack) begin
          state <= ST_EXEC;
          i_req <= 1'b0;
        end
        ST_EXEC: begin
          if (is_mem) begin
            state <= ST_MEM;
            d_req <= 1'b1;
          end else if (misaligned) begin
            state  <= ST_HALT;
            halted <= 1'b1;
            err    <= 1'b1;
          end else if (is_ebreak && HALT_ON_EBREAK) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else begin
            state <= ST_FETCH;
            i_req <= 1'b1;
          end
        end
        ST_MEM: if (d_ack) begin
          d_req <= 1'b0;
          if (misaligned) begin
            state  <= ST_HALT;
            halted <= 1'b1;
            err    <= 1'b1;
          end else begin
            state <= ST_FETCH;
            i_req <= 1'b1;
          end
        end
        default: begin
          state  <= ST_HALT;
          i_req  <= 1'b0;
          d_req  <= 1'b0;
          halted <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/core_regfile.sv
// 32 x 32 register file, two async read ports, one write port; x0 reads as zero.
module core_regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] regs [32];

  always_ff @(posedge clk) begin
    if (we && (waddr != 5'd0)) regs[waddr] <= wdata;
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];

endmodule

// File: rtl/core_mc.sv
// Multi-cycle RV32I core top: pc/ir/counters around the sequencer and the reused datapath.
module core_mc
  import core_mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter bit          HALT_ON_EBREAK = 1'b1,
  parameter int          CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  output logic             i_req,
  output logic [31:0]      i_addr,
  input  logic             i_ack,
  input  logic [31:0]      i_rdata,
  output logic             d_req,
  output logic [31:0]      d_addr,
  output logic [3:0]       d_wen,
  output logic [31:0]      d_wdata,
  input  logic             d_ack,
  input  logic [31:0]      d_rdata,
  output logic             halted,
  output logic             err,
  output logic             retire,
  output logic [31:0]      pc_o,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  state_t      state;
  logic [31:0] pc, ir, nextpc, rs1_data, rs2_data, wdata, alu_a, alu_b, alu_y;
  logic [31:0] mem_addr, mem_wdata;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [3:0]  alu_op, mem_wen;
  logic        wreg, commit, ir_load, misaligned;

  assign misaligned = |nextpc[1:0];
  assign i_addr     = pc;
  assign pc_o       = pc;
  assign retire     = commit;
  assign d_addr     = mem_addr;
  assign d_wdata    = mem_wdata;
  assign d_wen      = d_req ? mem_wen : 4'b0000;

  core_mc_fsm #(.HALT_ON_EBREAK(HALT_ON_EBREAK)) u_fsm (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .i_ack      (i_ack),
    .d_ack      (d_ack),
    .is_mem     (is_mem_op(ir)),
    .is_ebreak  (ir == INSN_EBREAK),
    .misaligned (misaligned),
    .state      (state),
    .i_req      (i_req),
    .d_req      (d_req),
    .halted     (halted),
    .err        (err),
    .commit     (commit),
    .ir_load    (ir_load)
  );

  core_regfile u_rf (
    .clk    (clk),
    .we     (wreg & commit),
    .waddr  (rd_addr),
    .wdata  (wdata),
    .raddr1 (rs1_addr),
    .raddr2 (rs2_addr),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

  core_alu u_alu (
    .op (alu_op),
    .a  (alu_a),
    .b  (alu_b),
    .y  (alu_y)
  );

  core_ctrl u_ctrl (
    .ir         (ir),
    .pc         (pc),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .alu_y      (alu_y),
    .d_mem_data (d_rdata),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rd_addr    (rd_addr),
    .wreg       (wreg),
    .wdata      (wdata),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .nextpc     (nextpc),
    .mem_addr   (mem_addr),
    .mem_wen    (mem_wen),
    .mem_wdata  (mem_wdata)
  );

  // A misaligned target leaves pc on the faulting instruction.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc          <= RESET_PC;
      ir          <= '0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (ir_load) ir <= i_rdata;
      if (commit && !misaligned) pc <= nextpc;
      if (commit) instret_cnt <= instret_cnt + CNT_W'(1);
      if (state inside {ST_FETCH, ST_EXEC, ST_MEM}) cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_core_mc.sv
// Directed bench for core_mc: handshakes with wait states, commit gating, errors, halt and reset.
module tb_core_mc;

  localparam logic [31:0] ADDI_X1_5  = 32'h0050_0093;
  localparam logic [31:0] SW_X1_8    = 32'h0010_2423;
  localparam logic [31:0] LW_X2_8    = 32'h0080_2103;
  localparam logic [31:0] SW_X2_12   = 32'h0020_2623;
  localparam logic [31:0] JALR_X3_MA = 32'h1020_01E7;
  localparam logic [31:0] EBREAK     = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rstn, start, i_ack, d_ack;
  logic [31:0] i_rdata, d_rdata;

  logic        i_req, d_req, halted, err, retire;
  logic [31:0] i_addr, d_addr, d_wdata, pc_o;
  logic [3:0]  d_wen;
  logic [31:0] cycle_cnt, instret_cnt;

  logic        n_i_req, n_d_req, n_halted, n_err, n_retire;
  logic [31:0] n_i_addr, n_d_addr, n_d_wdata, n_pc_o;
  logic [3:0]  n_d_wen;
  logic [31:0] n_cycle_cnt, n_instret_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  core_mc #(.RESET_PC(32'h100), .HALT_ON_EBREAK(1'b1), .CNT_W(32)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wen(d_wen), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .halted(halted), .err(err), .retire(retire), .pc_o(pc_o),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  core_mc #(.RESET_PC(32'h100), .HALT_ON_EBREAK(1'b0), .CNT_W(32)) dut_nh (
    .clk(clk), .rstn(rstn), .start(start),
    .i_req(n_i_req), .i_addr(n_i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(n_d_req), .d_addr(n_d_addr), .d_wen(n_d_wen), .d_wdata(n_d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .halted(n_halted), .err(n_err), .retire(n_retire), .pc_o(n_pc_o),
    .cycle_cnt(n_cycle_cnt), .instret_cnt(n_instret_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge in FETCH; leaves at the negedge of the EXEC cycle.
  task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] insn,
                          input int waits);
    for (int i = 0; i < waits; i++) begin
      chk({tag, "_ireq_wait"}, i_req, 1'b1);
      chk({tag, "_iaddr_wait"}, i_addr, addr);
      @(negedge clk);
    end
    chk({tag, "_ireq"}, i_req, 1'b1);
    chk({tag, "_iaddr"}, i_addr, addr);
    i_ack   = 1'b1;
    i_rdata = insn;
    @(negedge clk);
    i_ack   = 1'b0;
    i_rdata = '0;
  endtask

  // Entered at a negedge in MEM; leaves at the negedge after the d_ack cycle.
  task automatic do_mem(input string tag, input int waits, input logic [31:0] rdata,
                        input logic [31:0] addr, input logic [3:0] wen,
                        input logic [31:0] wdata, input bit chk_wdata);
    for (int i = 0; i < waits; i++) begin
      chk({tag, "_dreq_wait"}, d_req, 1'b1);
      chk({tag, "_daddr_wait"}, d_addr, addr);
      chk({tag, "_dwen_wait"}, d_wen, wen);
      if (chk_wdata) chk({tag, "_dwdata_wait"}, d_wdata, wdata);
      chk({tag, "_no_retire_wait"}, retire, 1'b0);
      @(negedge clk);
    end
    chk({tag, "_dreq"}, d_req, 1'b1);
    chk({tag, "_daddr"}, d_addr, addr);
    chk({tag, "_dwen"}, d_wen, wen);
    if (chk_wdata) chk({tag, "_dwdata"}, d_wdata, wdata);
    d_ack   = 1'b1;
    d_rdata = rdata;
    #1;
    chk({tag, "_retire_on_ack"}, retire, 1'b1);
    @(negedge clk);
    d_ack   = 1'b0;
    d_rdata = '0;
    chk({tag, "_dreq_drop"}, d_req, 1'b0);
    chk({tag, "_dwen_drop"}, d_wen, 4'h0);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; i_ack = 1'b0; d_ack = 1'b0; i_rdata = '0; d_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ireq", i_req, 1'b0);
    chk("rst_dreq", d_req, 1'b0);
    chk("rst_dwen", d_wen, 4'h0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_retire", retire, 1'b0);
    chk("rst_pc", pc_o, 32'h100);
    chk("rst_cycle", cycle_cnt, 32'd0);
    chk("rst_instret", instret_cnt, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_ireq", i_req, 1'b0);
    chk("idle_cycle", cycle_cnt, 32'd0);

    // ADDI x1,x0,5 with three fetch wait cycles
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    do_fetch("addi", 32'h100, ADDI_X1_5, 3);
    chk("addi_retire", retire, 1'b1);
    chk("addi_exec_ireq", i_req, 1'b0);
    @(negedge clk);
    chk("addi_pc", pc_o, 32'h104);
    chk("addi_cycle", cycle_cnt, 32'd5);
    chk("addi_instret", instret_cnt, 32'd1);
    chk("addi_retire_pulse", retire, 1'b0);

    // SW x1,8(x0) with four data wait cycles
    do_fetch("sw", 32'h104, SW_X1_8, 0);
    chk("sw_exec_retire", retire, 1'b0);
    chk("sw_exec_dreq", d_req, 1'b0);
    @(negedge clk);
    do_mem("sw", 4, 32'h0, 32'd8, 4'hF, 32'd5, 1'b1);
    chk("sw_pc", pc_o, 32'h108);
    chk("sw_instret", instret_cnt, 32'd2);

    // LW x2,8(x0) with a spurious d_ack held through the fetch
    d_ack   = 1'b1;
    d_rdata = 32'hBAD0_BAD0;
    do_fetch("lw", 32'h108, LW_X2_8, 1);
    d_ack   = 1'b0;
    d_rdata = '0;
    chk("spur_instret", instret_cnt, 32'd2);
    chk("spur_dreq", d_req, 1'b0);
    chk("lw_exec_retire", retire, 1'b0);
    @(negedge clk);
    do_mem("lw", 1, 32'hDEAD_BEEF, 32'd8, 4'h0, 32'h0, 1'b0);
    chk("lw_pc", pc_o, 32'h10C);
    chk("lw_instret", instret_cnt, 32'd3);

    // SW x2,12(x0) exposes the loaded value
    do_fetch("sw2", 32'h10C, SW_X2_12, 0);
    @(negedge clk);
    do_mem("sw2", 0, 32'h0, 32'd12, 4'hF, 32'hDEAD_BEEF, 1'b1);
    chk("sw2_pc", pc_o, 32'h110);

    // JALR x3,0x102(x0): misaligned target
    do_fetch("jalr", 32'h110, JALR_X3_MA, 1);
    chk("jalr_retire", retire, 1'b1);
    chk("jalr_err_pre", err, 1'b0);
    @(negedge clk);
    chk("jalr_err", err, 1'b1);
    chk("jalr_halted", halted, 1'b1);
    chk("jalr_pc", pc_o, 32'h110);
    chk("jalr_instret", instret_cnt, 32'd5);
    chk("jalr_ireq", i_req, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("err_start_ireq", i_req, 1'b0);
    chk("err_start_halted", halted, 1'b1);

    // Reset while a store waits for d_ack
    rstn = 1'b0;
    @(negedge clk);
    rstn  = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    do_fetch("mid", 32'h100, SW_X1_8, 0);
    @(negedge clk);
    chk("mid_dreq", d_req, 1'b1);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_dreq", d_req, 1'b0);
    chk("mid_rst_ireq", i_req, 1'b0);
    chk("mid_rst_pc", pc_o, 32'h100);
    chk("mid_rst_cycle", cycle_cnt, 32'd0);
    chk("mid_rst_instret", instret_cnt, 32'd0);
    chk("mid_rst_err", err, 1'b0);
    @(negedge clk);
    rstn    = 1'b1;
    d_ack   = 1'b1;
    d_rdata = 32'h1234_5678;
    i_ack   = 1'b1;
    i_rdata = LW_X2_8;
    #1;
    chk("late_ack_retire", retire, 1'b0);
    @(negedge clk);
    d_ack = 1'b0; d_rdata = '0; i_ack = 1'b0; i_rdata = '0;
    chk("late_ack_ireq", i_req, 1'b0);
    chk("late_ack_instret", instret_cnt, 32'd0);
    chk("late_ack_cycle", cycle_cnt, 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    do_fetch("post", 32'h100, SW_X2_12, 0);
    @(negedge clk);
    do_mem("post", 0, 32'h0, 32'd12, 4'hF, 32'hDEAD_BEEF, 1'b1);

    // EBREAK: halts dut, is a NOP in dut_nh
    do_fetch("ebrk", 32'h104, EBREAK, 0);
    chk("ebrk_retire", retire, 1'b1);
    chk("ebrk_nh_retire", n_retire, 1'b1);
    @(negedge clk);
    chk("ebrk_halted", halted, 1'b1);
    chk("ebrk_err", err, 1'b0);
    chk("ebrk_ireq", i_req, 1'b0);
    chk("ebrk_instret", instret_cnt, 32'd2);
    chk("ebrk_nh_halted", n_halted, 1'b0);
    chk("ebrk_nh_pc", n_pc_o, 32'h108);
    chk("ebrk_nh_ireq", n_i_req, 1'b1);
    chk("ebrk_nh_iaddr", n_i_addr, 32'h108);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("halt_start_ireq", i_req, 1'b0);
    chk("halt_start_halted", halted, 1'b1);
    i_ack   = 1'b1;
    i_rdata = ADDI_X1_5;
    @(negedge clk);
    i_ack   = 1'b0;
    i_rdata = '0;
    chk("nh_addi_retire", n_retire, 1'b1);
    chk("halt_no_retire", retire, 1'b0);
    @(negedge clk);
    chk("nh_addi_pc", n_pc_o, 32'h10C);
    chk("nh_addi_instret", n_instret_cnt, 32'd3);
    chk("halt_instret", instret_cnt, 32'd2);
    chk("halt_still", halted, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
